// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, downstream forwarding sources, EX outputs.
// master = surrounding pipeline (drives ID/MEM/WB), slave = id_ex_stage.
interface id_ex_stage_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RAW = 5,
    parameter int unsigned FW  = 6
);
    localparam int unsigned SHW = $clog2(DW);

    logic [RAW-1:0] id_rs_addr;
    logic [RAW-1:0] id_rt_addr;
    logic [RAW-1:0] id_wr_addr;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [SHW-1:0] id_shamt;
    logic [DW-1:0]  id_imm;
    logic [FW-1:0]  id_alufun;
    logic           id_alusrc1;
    logic           id_alusrc2;
    logic           id_regwrite;
    logic           id_memread;
    logic           id_memwrite;
    logic           id_memtoreg;
    logic           stall_in;
    logic           flush;
    logic           mem_regwrite;
    logic [RAW-1:0] mem_wr_addr;
    logic [DW-1:0]  mem_result;
    logic           wb_regwrite;
    logic [RAW-1:0] wb_wr_addr;
    logic [DW-1:0]  wb_data;
    logic           load_use_stall;
    logic [DW-1:0]  ex_a;
    logic [DW-1:0]  ex_b;
    logic [DW-1:0]  ex_store_data;
    logic [FW-1:0]  ex_alufun;
    logic [RAW-1:0] ex_wr_addr;
    logic           ex_regwrite;
    logic           ex_memread;
    logic           ex_memwrite;
    logic           ex_memtoreg;

    modport master (
        output id_rs_addr, id_rt_addr, id_wr_addr, id_rs_data, id_rt_data,
               id_shamt, id_imm, id_alufun, id_alusrc1, id_alusrc2,
               id_regwrite, id_memread, id_memwrite, id_memtoreg,
               stall_in, flush,
               mem_regwrite, mem_wr_addr, mem_result,
               wb_regwrite, wb_wr_addr, wb_data,
        input  load_use_stall, ex_a, ex_b, ex_store_data, ex_alufun, ex_wr_addr,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_wr_addr, id_rs_data, id_rt_data,
               id_shamt, id_imm, id_alufun, id_alusrc1, id_alusrc2,
               id_regwrite, id_memread, id_memwrite, id_memtoreg,
               stall_in, flush,
               mem_regwrite, mem_wr_addr, mem_result,
               wb_regwrite, wb_wr_addr, wb_data,
        output load_use_stall, ex_a, ex_b, ex_store_data, ex_alufun, ex_wr_addr,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection and hazard detection.
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : MEM/WB -> EX forwarding, stall only on load-use.
//   undefined : no forwarding, stall while any in-flight EX/MEM producer
//               targets an ID source (one bubble per stall cycle).
module id_ex_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RAW = 5,
    parameter int unsigned FW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam int unsigned SHW = $clog2(DW);

    typedef struct packed {
        logic [RAW-1:0] rs_addr;
        logic [RAW-1:0] rt_addr;
        logic [RAW-1:0] wr_addr;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [SHW-1:0] shamt;
        logic [DW-1:0]  imm;
        logic [FW-1:0]  alufun;
        logic           alusrc1;
        logic           alusrc2;
        logic           regwrite;
        logic           memread;
        logic           memwrite;
        logic           memtoreg;
    } idex_t;

    idex_t          id_w;
    idex_t          idex_d;
    idex_t          idex_q;
    logic           load_use_stall_c;
    logic [DW-1:0]  fwd_rs;
    logic [DW-1:0]  fwd_rt;

    // Gather the ID-stage fields into one payload
    always_comb begin
        id_w          = '0;
        id_w.rs_addr  = bus.id_rs_addr;
        id_w.rt_addr  = bus.id_rt_addr;
        id_w.wr_addr  = bus.id_wr_addr;
        id_w.rs_data  = bus.id_rs_data;
        id_w.rt_data  = bus.id_rt_data;
        id_w.shamt    = bus.id_shamt;
        id_w.imm      = bus.id_imm;
        id_w.alufun   = bus.id_alufun;
        id_w.alusrc1  = bus.id_alusrc1;
        id_w.alusrc2  = bus.id_alusrc2;
        id_w.regwrite = bus.id_regwrite;
        id_w.memread  = bus.id_memread;
        id_w.memwrite = bus.id_memwrite;
        id_w.memtoreg = bus.id_memtoreg;
    end

`ifdef ID_EX_FORWARD_EN
    // Load in EX whose destination is an ID source: data not ready until WB
    always_comb begin
        load_use_stall_c = 1'b0;
        if (!bus.flush && idex_q.memread && (idex_q.wr_addr != '0) &&
            ((idex_q.wr_addr == bus.id_rs_addr) || (idex_q.wr_addr == bus.id_rt_addr))) begin
            load_use_stall_c = 1'b1;
        end
    end

    // Operand bypass, nearest producer (MEM) first; $0 never forwards
    always_comb begin
        fwd_rs = idex_q.rs_data;
        fwd_rt = idex_q.rt_data;
        if (bus.mem_regwrite && (bus.mem_wr_addr == idex_q.rs_addr) && (idex_q.rs_addr != '0)) begin
            fwd_rs = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_wr_addr == idex_q.rs_addr) && (idex_q.rs_addr != '0)) begin
            fwd_rs = bus.wb_data;
        end
        if (bus.mem_regwrite && (bus.mem_wr_addr == idex_q.rt_addr) && (idex_q.rt_addr != '0)) begin
            fwd_rt = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_wr_addr == idex_q.rt_addr) && (idex_q.rt_addr != '0)) begin
            fwd_rt = bus.wb_data;
        end
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{bus.mem_result, bus.wb_regwrite, bus.wb_wr_addr,
                            bus.wb_data, idex_q.rs_addr, idex_q.rt_addr};

    // Stall while EX or MEM will still write a register ID wants to read
    always_comb begin
        load_use_stall_c = 1'b0;
        if (!bus.flush) begin
            if ((bus.id_rs_addr != '0) &&
                ((idex_q.regwrite && (idex_q.wr_addr == bus.id_rs_addr)) ||
                 (bus.mem_regwrite && (bus.mem_wr_addr == bus.id_rs_addr)))) begin
                load_use_stall_c = 1'b1;
            end
            if ((bus.id_rt_addr != '0) &&
                ((idex_q.regwrite && (idex_q.wr_addr == bus.id_rt_addr)) ||
                 (bus.mem_regwrite && (bus.mem_wr_addr == bus.id_rt_addr)))) begin
                load_use_stall_c = 1'b1;
            end
        end
    end

    // Operands come straight from the register
    always_comb begin
        fwd_rs = idex_q.rs_data;
        fwd_rt = idex_q.rt_data;
    end
`endif

    // Next-state: hold on global stall, bubble on flush or hazard, else load ID
    always_comb begin
        idex_d = idex_q;
        if (bus.stall_in) begin
            idex_d = idex_q;
        end else if (bus.flush || load_use_stall_c) begin
            idex_d = '0;
        end else begin
            idex_d = id_w;
        end
    end

    // ID/EX register with synchronous reset to an empty slot
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // EX-side operand muxes and registered control
    assign bus.ex_a           = idex_q.alusrc1 ? DW'(idex_q.shamt) : fwd_rs;
    assign bus.ex_b           = idex_q.alusrc2 ? idex_q.imm : fwd_rt;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_alufun      = idex_q.alufun;
    assign bus.ex_wr_addr     = idex_q.wr_addr;
    assign bus.ex_regwrite    = idex_q.regwrite;
    assign bus.ex_memread     = idex_q.memread;
    assign bus.ex_memwrite    = idex_q.memwrite;
    assign bus.ex_memtoreg    = idex_q.memtoreg;
    assign bus.load_use_stall = load_use_stall_c;

endmodule
